accelbrot_com_axi_arbiter: RTL and testbench
============================================

# accelbrot_com_axi_arbiter

Round-robin arbiter that merges `NUM_REQ` valid/ready request streams (per-core result/command streams) onto one shared valid/ready output toward the host interface. It holds one registered output beat, so it is a drop-in register stage in the same style as the existing stream slices. It tags each beat with the source index. It keeps packets from different requesters from interleaving when packet lock is compiled in.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 32: payload width.
- `ID_WIDTH`, derived localparam, `$clog2(NUM_REQ)`: source-index width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock.
- `rstn`  in  1  asynchronous active-low reset.
- `req_data`  in  `NUM_REQ`×`DATA_WIDTH`  per-requester payload.
- `req_valid`  in  `NUM_REQ`  per-requester valid.
- `req_last`  in  `NUM_REQ`  per-requester end-of-packet.
- `req_ready`  out  `NUM_REQ`  per-requester ready; one-hot or zero.
- `out_data`  out  `DATA_WIDTH`  registered payload.
- `out_id`  out  `ID_WIDTH`  registered source index.
- `out_last`  out  1  registered end-of-packet.
- `out_valid`  out  1  registered valid.
- `out_ready`  in  1  downstream ready.

## Operation
- Internal signal `shift_en = out_ready | ~out_valid`.
  - The output register loads only when `shift_en` is 1.
  - Otherwise the output register holds its value.
- State machine:
  - `IDLE` (arbitrating).
  - `LOCK` (holding the grant for requester `lock_id` until its last beat).
- Grant selection:
  - In `IDLE`: `grant` is the first index with `req_valid` = 1, searching cyclically from `ptr+1` (mod `NUM_REQ`). `grant_vld` = any `req_valid`.
  - In `LOCK`: `grant` = `lock_id`, and `grant_vld` = `req_valid[lock_id]`.
- `req_ready[i] = rstn & shift_en & grant_vld & (grant == i)`.
- Beat acceptance, when `req_valid[g] & req_ready[g]` for granted index `g`:
  - `out_data`/`out_last` load `req_data[g]`/`req_last[g]`.
  - `out_id` loads `g`.
  - `out_valid` is set to 1.
- When `shift_en` is 1 and no beat is accepted, `out_valid` is cleared to 0.
- Transitions:
  - `IDLE` → `LOCK`: accepted beat with `last` = 0. Sets `lock_id = g`.
  - `IDLE` stays `IDLE`: accepted beat with `last` = 1. Sets `ptr = g`.
  - `LOCK` → `IDLE`: accepted beat with `last` = 1. Sets `ptr = lock_id`.
  - `LOCK` while `req_valid[lock_id]` = 0: stays in `LOCK`. Other requesters are never granted (a stalled packet owner blocks the bus by design).
- Reset values:
  - `out_valid`, `out_last`, `out_data`, `out_id` = 0.
  - State = `IDLE`; `lock_id` = 0.
  - `ptr = NUM_REQ-1`, so requester 0 has first priority.
  - `req_ready` = 0 while `rstn` is low.
- Reset asserted mid-packet: the packet is abandoned, all outputs clear immediately, and state returns to `IDLE`. No recovery of the partial packet.

## Timing
- Latency: a beat accepted at edge N is visible on `out_*` after edge N, with `out_valid` high in cycle N+1.
- Throughput: one beat per cycle while `out_ready` = 1, including back-to-back switches between requesters.
- `req_ready` depends combinationally on `out_ready`, `out_valid`, state, `ptr` and `req_valid`. There is no combinational path from any `req_data` to `out_*`.
- While `out_valid & ~out_ready`: `out_*` are stable and all `req_ready` = 0.
- The grant is re-evaluated only at `IDLE` with `shift_en` = 1. A requester that drops `req_valid` before its handshake loses the slot without penalty.

## Configuration
- Macro: `ACCELBROT_ARB_PKT_LOCK_EN`.
- Defined: packet lock as described above (`IDLE`/`LOCK`).
- Undefined:
  - The `LOCK` state and `lock_id` are not built.
  - Every accepted beat updates `ptr = g`, so arbitration is per beat and packets may interleave.
  - `out_last` still passes through unchanged.

## Structure
- Shared package `accelbrot_com_pkg` holds:
  - `arb_state_t` enum (`ARB_IDLE`, `ARB_LOCK`).
  - `ARB_MAX_REQ = 16` constant, checked by an elaboration-time assertion on `NUM_REQ`.
- Sub-module `accelbrot_com_rr_pick`:
  - Combinational rotating priority picker.
  - Inputs: request vector and `ptr`.
  - Outputs: `grant` index and `grant_vld`.

## Test plan
- Requester 0 sends a 3-beat packet 0xA0,0xA1,0xA2 (last on 0xA2), `out_ready` = 1 → the same data appears on `out_data` one cycle later with `out_id` = 0 and `out_last` only on 0xA2, at 1 beat per cycle.
- All 4 requesters hold single-beat packets valid, `out_ready` = 1 → `out_id` sequence 0,1,2,3,0,1…, with no idle cycles.
- Macro defined: requester 1 sends a 4-beat packet while requester 2 is valid → requester 2's first beat follows requester 1's last beat; no interleaving.
- `out_ready` held 0 for 3 cycles with `out_valid` = 1 → `out_*` unchanged, all `req_ready` = 0, no beat lost or duplicated after release.
- `rstn` pulsed low mid-packet on requester 3 → `out_valid` = 0 immediately. After release with requesters 0 and 3 valid, the first grant is to 0.
- Macro undefined: requesters 1 and 2 each send 2-beat packets simultaneously → `out_id` sequence 1,2,1,2.

Source files
------------

// File: rtl/accelbrot_com_pkg.sv
// accelbrot_com_pkg: shared types and limits for the accelbrot host-communication blocks.
package accelbrot_com_pkg;

    localparam int ARB_MAX_REQ = 16;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/accelbrot_com_rr_pick.sv
// accelbrot_com_rr_pick: rotating-priority picker, first request found searching from ptr_i+1.
module accelbrot_com_rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] ptr_i,
    output logic [ID_WIDTH-1:0] grant_o,
    output logic                grant_vld_o
);

    logic [ID_WIDTH-1:0] idx;

    // Walk from the farthest candidate back to ptr_i+1 so the nearest hit wins.
    always_comb begin
        grant_o = '0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_WIDTH'((int'(ptr_i) + k) % NUM_REQ);
            if (req_i[idx]) grant_o = idx;
        end
        grant_vld_o = |req_i;
    end

endmodule

// File: rtl/accelbrot_com_axi_arbiter.sv
// accelbrot_com_axi_arbiter: round-robin merge of NUM_REQ valid/ready streams into one registered beat tagged with its source.
// Define ACCELBROT_ARB_PKT_LOCK_EN to hold the grant until a packet's last beat (no interleaving).
module accelbrot_com_axi_arbiter
    import accelbrot_com_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [ID_WIDTH-1:0]           out_id,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);

    if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
        $error("accelbrot_com_axi_arbiter: NUM_REQ must be in 2..%0d", ARB_MAX_REQ);
    end

    logic                  shift_en, grant_vld, pick_vld, accept;
    logic [ID_WIDTH-1:0]   grant, pick, ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [ID_WIDTH-1:0]   out_id_q;
    logic                  out_last_q, out_valid_q;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign data_arr[i]  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign req_ready[i] = rstn & shift_en & grant_vld & (grant == ID_WIDTH'(i));
    end

    accelbrot_com_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (pick),
        .grant_vld_o (pick_vld)
    );

    assign shift_en = out_ready | ~out_valid_q;
    assign accept   = rstn & shift_en & grant_vld;

    // Pointer starts at the top index so requester 0 is searched first after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr_q <= ID_WIDTH'(NUM_REQ - 1);
        else       ptr_q <= ptr_d;
    end

`ifdef ACCELBROT_ARB_PKT_LOCK_EN
    arb_state_t          state_q, state_d;
    logic [ID_WIDTH-1:0] lock_id_q, lock_id_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ARB_IDLE;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end

    // The pointer only advances on packet boundaries, so round-robin is fair per packet.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        ptr_d     = ptr_q;
        if (accept) begin
            if (req_last[grant]) begin
                state_d = ARB_IDLE;
                ptr_d   = grant;
            end else if (state_q == ARB_IDLE) begin
                state_d   = ARB_LOCK;
                lock_id_d = grant;
            end
        end
    end

    always_comb begin
        grant     = state_q == ARB_LOCK ? lock_id_q : pick;
        grant_vld = state_q == ARB_LOCK ? req_valid[lock_id_q] : pick_vld;
    end
`else
    assign ptr_d     = accept ? grant : ptr_q;
    assign grant     = pick;
    assign grant_vld = pick_vld;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else if (shift_en) begin
            out_valid_q <= accept;
            if (accept) begin
                out_data_q <= data_arr[grant];
                out_last_q <= req_last[grant];
                out_id_q   <= grant;
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_accelbrot_com_axi_arbiter.sv
// tb_accelbrot_com_axi_arbiter: queue-based reference model feeding a scoreboard, directed scenarios then random traffic.
// Follows ACCELBROT_ARB_PKT_LOCK_EN the same way the design does.
module tb_accelbrot_com_axi_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
    typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] d; logic l; } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_last = '0;
    logic [N-1:0]  req_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_id;
    logic          out_last, out_valid;
    logic          out_ready = 1'b0;

    beat_t src [N][$];
    exp_t  sb [$];
    int    checks = 0, failures = 0;
    int    m_ptr = N - 1, m_lock = 0, gap = 0;
    bit    m_vld = 1'b0, m_locked = 1'b0;

    logic          hold_prev = 1'b0;
    logic [DW-1:0] p_d;
    logic [IW-1:0] p_id;
    logic          p_l;

    accelbrot_com_axi_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push_pkt(input int r, input int len, input logic [DW-1:0] base);
        for (int k = 0; k < len; k++) src[r].push_back('{d: base + DW'(k), l: (k == len - 1)});
    endtask

    function automatic bit busy();
        bit b = m_vld || sb.size() != 0;
        for (int i = 0; i < N; i++) if (src[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    // One clock: drive requesters from their queues, then predict the grant from the
    // round-robin/packet rules and log the accepted beat as the expected output.
    task automatic cycle(input logic rdy);
        int    g;
        bit    shift;
        beat_t b;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_valid[i] = src[i].size() > 0 && $urandom_range(99) >= gap;
            if (src[i].size() > 0) begin
                req_data[i*DW +: DW] = src[i][0].d;
                req_last[i]          = src[i][0].l;
            end else begin
                req_data[i*DW +: DW] = $urandom;
                req_last[i]          = 1'($urandom);
            end
        end
        out_ready = rdy;
        #1;
        chk("out_valid", out_valid, m_vld);
        shift = rdy || !m_vld;
        g = -1;
        if (shift && m_locked) begin
            if (req_valid[m_lock]) g = m_lock;
        end else if (shift) begin
            for (int k = 1; k <= N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        chk("req_ready", req_ready, g < 0 ? 0 : 1 << g);
        if (shift) m_vld = g >= 0;
        if (g >= 0) begin
            b = src[g].pop_front();
            sb.push_back('{id: IW'(g), d: b.d, l: b.l});
`ifdef ACCELBROT_ARB_PKT_LOCK_EN
            m_locked = !b.l;
            m_lock   = g;
            if (b.l) m_ptr = g;
`else
            m_ptr = g;
`endif
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_req_ready", req_ready, 0);
        for (int i = 0; i < N; i++) src[i].delete();
        sb.delete();
        m_vld = 1'b0;
        m_locked = 1'b0;
        m_ptr = N - 1;
        m_lock = 0;
        repeat (2) @(negedge clk);
        req_valid = '0;
        rstn = 1'b1;
    endtask

    // Monitor: just before each rising edge, a presented beat that is being taken must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        #4;
        if (!rstn) hold_prev = 1'b0;
        else begin
            if (hold_prev) begin
                chk("stall_data", out_data, p_d);
                chk("stall_id", out_id, p_id);
                chk("stall_last", out_last, p_l);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual id=%0d data=%0h required=no beat", out_id, out_data);
                end else begin
                    e = sb.pop_front();
                    chk("beat_id", out_id, e.id);
                    chk("beat_data", out_data, e.d);
                    chk("beat_last", out_last, e.l);
                end
            end
            hold_prev = out_valid && !out_ready;
            p_d  = out_data;
            p_id = out_id;
            p_l  = out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        req_valid = '1;
        do_reset();
        push_pkt(0, 3, 32'hA0);
        repeat (5) cycle(1'b1);
        for (int i = 0; i < N; i++) begin
            push_pkt(i, 1, 32'h100 + i * 16);
            push_pkt(i, 1, 32'h108 + i * 16);
        end
        repeat (10) cycle(1'b1);
        push_pkt(1, 4, 32'h210);
        push_pkt(2, 1, 32'h220);
        push_pkt(2, 1, 32'h228);
        repeat (9) cycle(1'b1);
        push_pkt(0, 2, 32'h300);
        push_pkt(1, 2, 32'h310);
        repeat (2) cycle(1'b1);
        repeat (3) cycle(1'b0);
        repeat (6) cycle(1'b1);
        push_pkt(3, 4, 32'h400);
        repeat (2) cycle(1'b1);
        do_reset();
        push_pkt(0, 1, 32'h500);
        push_pkt(3, 1, 32'h530);
        repeat (4) cycle(1'b1);
        push_pkt(1, 2, 32'h610);
        push_pkt(2, 2, 32'h620);
        repeat (6) cycle(1'b1);
        gap = 30;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (src[i].size() < 4 && $urandom_range(7) == 0) push_pkt(i, $urandom_range(1, 4), $urandom);
            cycle($urandom_range(3) != 0);
            if (c == 200) do_reset();
        end
        gap = 0;
        for (int c = 0; c < 300 && busy(); c++) cycle(1'b1);
        @(negedge clk);
        #5;
        chk("drain_sb", sb.size(), 0);
        chk("drain_busy", busy(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
